// File: rtl/instr_decode_stage_pkg.sv
// Shared types and LEGv8 opcode constants for the decode stage.
package instr_decode_stage_pkg;

  localparam int unsigned INSTR_LEN = 32;
  localparam int unsigned IMM_W_DEF = 64;
  localparam int unsigned FMT_W     = 3;
  localparam int unsigned OPC_W     = 11;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned SHAMT_W   = 6;

  typedef enum logic [FMT_W-1:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_D       = 3'd2,
    FMT_B       = 3'd3,
    FMT_CB      = 3'd4,
    FMT_IW      = 3'd5,
    FMT_ILLEGAL = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_st_e;

  // B format, instr[31:26]
  localparam logic [5:0]  OP_B      = 6'b000101;
  localparam logic [5:0]  OP_BL     = 6'b100101;
  // CB format, instr[31:24]
  localparam logic [7:0]  OP_CBZ    = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ   = 8'b10110101;
  localparam logic [7:0]  OP_BCOND  = 8'b01010100;
  // IW format, instr[31:23]
  localparam logic [8:0]  OP_MOVZ   = 9'b110100101;
  localparam logic [8:0]  OP_MOVK   = 9'b111100101;
  // I format, instr[31:22]
  localparam logic [9:0]  OP_ADDI   = 10'b1001000100;
  localparam logic [9:0]  OP_ADDIS  = 10'b1011000100;
  localparam logic [9:0]  OP_SUBI   = 10'b1101000100;
  localparam logic [9:0]  OP_SUBIS  = 10'b1111000100;
  localparam logic [9:0]  OP_ANDI   = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI   = 10'b1011001000;
  localparam logic [9:0]  OP_EORI   = 10'b1101001000;
  localparam logic [9:0]  OP_ANDIS  = 10'b1111001000;
  // D format, instr[31:21]
  localparam logic [10:0] OP_LDUR   = 11'b11111000010;
  localparam logic [10:0] OP_STUR   = 11'b11111000000;
  localparam logic [10:0] OP_LDURSW = 11'b10111000100;
  localparam logic [10:0] OP_STURW  = 11'b10111000000;
  localparam logic [10:0] OP_LDURH  = 11'b01111000010;
  localparam logic [10:0] OP_STURH  = 11'b01111000000;
  localparam logic [10:0] OP_LDURB  = 11'b00111000010;
  localparam logic [10:0] OP_STURB  = 11'b00111000000;
  // R format, instr[31:21]
  localparam logic [10:0] OP_ADD    = 11'b10001011000;
  localparam logic [10:0] OP_SUB    = 11'b11001011000;
  localparam logic [10:0] OP_AND    = 11'b10001010000;
  localparam logic [10:0] OP_ORR    = 11'b10101010000;
  localparam logic [10:0] OP_EOR    = 11'b11001010000;
  localparam logic [10:0] OP_ADDS   = 11'b10101011000;
  localparam logic [10:0] OP_SUBS   = 11'b11101011000;
  localparam logic [10:0] OP_ANDS   = 11'b11101010000;
  localparam logic [10:0] OP_LSL    = 11'b11010011011;
  localparam logic [10:0] OP_LSR    = 11'b11010011010;
  localparam logic [10:0] OP_BR     = 11'b11010110000;

  // Decoded fields that travel with each entry (immediate and PC kept separately: parameterised widths)
  typedef struct packed {
    fmt_e               fmt;
    logic [OPC_W-1:0]   opcode;
    logic [REG_W-1:0]   rm;
    logic [REG_W-1:0]   rn;
    logic [REG_W-1:0]   rd;
    logic [SHAMT_W-1:0] shamt;
    logic               illegal;
  } dec_fields_t;

  function automatic logic is_i_op(input logic [9:0] op);
    return op inside {OP_ADDI, OP_ADDIS, OP_SUBI, OP_SUBIS,
                      OP_ANDI, OP_ORRI, OP_EORI, OP_ANDIS};
  endfunction

  function automatic logic is_d_op(input logic [10:0] op);
    return op inside {OP_LDUR, OP_STUR, OP_LDURSW, OP_STURW,
                      OP_LDURH, OP_STURH, OP_LDURB, OP_STURB};
  endfunction

  function automatic logic is_r_op(input logic [10:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_ADDS,
                      OP_SUBS, OP_ANDS, OP_LSL, OP_LSR, OP_BR};
  endfunction

endpackage

// File: rtl/instr_decode_stage_classify.sv
// Combinational LEGv8 classifier: word -> format, register fields, extended immediate.
module instr_decode_stage_classify
  import instr_decode_stage_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_LEN,
  parameter int unsigned IMM_W   = IMM_W_DEF
) (
  input  logic [INSTR_W-1:0] instr,
  output dec_fields_t        fields_c,
  output logic [IMM_W-1:0]   imm_c
);

  // Priority classification; fields are extracted regardless of format
  always_comb begin
    fields_c         = '0;
    imm_c            = '0;
    fields_c.fmt     = FMT_ILLEGAL;
    fields_c.opcode  = instr[31:21];
    fields_c.rm      = instr[20:16];
    fields_c.shamt   = instr[15:10];
    fields_c.rn      = instr[9:5];
    fields_c.rd      = instr[4:0];

    if (instr[31:26] == OP_B || instr[31:26] == OP_BL) begin
      fields_c.fmt = FMT_B;
      imm_c        = {{(IMM_W-26){instr[25]}}, instr[25:0]};
    end else if (instr[31:24] inside {OP_CBZ, OP_CBNZ, OP_BCOND}) begin
      fields_c.fmt = FMT_CB;
      imm_c        = {{(IMM_W-19){instr[23]}}, instr[23:5]};
    end else if (instr[31:23] inside {OP_MOVZ, OP_MOVK}) begin
      fields_c.fmt = FMT_IW;
      imm_c        = IMM_W'(instr[20:5]);
    end else if (is_i_op(instr[31:22])) begin
      fields_c.fmt = FMT_I;
      imm_c        = IMM_W'(instr[21:10]);
    end else if (is_d_op(instr[31:21])) begin
      fields_c.fmt = FMT_D;
      imm_c        = {{(IMM_W-9){instr[20]}}, instr[20:12]};
    end else if (is_r_op(instr[31:21])) begin
      fields_c.fmt = FMT_R;
    end

    fields_c.illegal = (fields_c.fmt == FMT_ILLEGAL);
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Two-entry (output + skid) handshaked decode stage between fetch and register read.
module instr_decode_stage
  import instr_decode_stage_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_LEN,
  parameter int unsigned IMM_W   = IMM_W_DEF,
  parameter int unsigned PC_W    = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  in_instr,
  input  logic [PC_W-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_W-1:0]     out_pc,
  output logic [FMT_W-1:0]    out_fmt,
  output logic [OPC_W-1:0]    out_opcode,
  output logic [REG_W-1:0]    out_rm,
  output logic [REG_W-1:0]    out_rn,
  output logic [REG_W-1:0]    out_rd,
  output logic [SHAMT_W-1:0]  out_shamt,
  output logic [IMM_W-1:0]    out_imm,
  output logic                out_illegal
);

  skid_st_e    state, state_nxt;
  dec_fields_t dec_c;
  logic [IMM_W-1:0] dec_imm_c;
  dec_fields_t out_q, skid_q;
  logic [IMM_W-1:0] out_imm_q, skid_imm_q;
  logic [PC_W-1:0]  out_pc_q, skid_pc_q;
  logic acc_c, drn_c;
  logic load_out_in_c, load_out_skid_c, load_skid_c;

  instr_decode_stage_classify #(
    .INSTR_W (INSTR_W),
    .IMM_W   (IMM_W)
  ) u_classify (
    .instr    (in_instr),
    .fields_c (dec_c),
    .imm_c    (dec_imm_c)
  );

  assign acc_c = in_valid & in_ready;
  assign drn_c = out_valid & out_ready;

  // State register plus registered handshake outputs derived from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != ST_EMPTY);
      in_ready  <= (state_nxt != ST_FULL);
    end
  end

  // Next-state: occupancy count; flush empties both entries
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_EMPTY: if (acc_c) state_nxt = ST_ONE;
      ST_ONE: begin
        if (acc_c && !drn_c)      state_nxt = ST_FULL;
        else if (!acc_c && drn_c) state_nxt = ST_EMPTY;
      end
      ST_FULL:  if (drn_c) state_nxt = ST_ONE;
      default:  state_nxt = ST_EMPTY;
    endcase
    if (flush) state_nxt = ST_EMPTY;
  end

  // Payload steering: input goes to output reg when it is free, otherwise to skid
  always_comb begin
    load_out_in_c   = 1'b0;
    load_out_skid_c = 1'b0;
    load_skid_c     = 1'b0;
    if (!flush) begin
      unique case (state)
        ST_EMPTY: load_out_in_c = acc_c;
        ST_ONE: begin
          load_out_in_c = acc_c & drn_c;
          load_skid_c   = acc_c & ~drn_c;
        end
        ST_FULL:  load_out_skid_c = drn_c;
        default: ;
      endcase
    end
  end

  // Output and skid payload registers
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q      <= '0;
      out_imm_q  <= '0;
      out_pc_q   <= '0;
      skid_q     <= '0;
      skid_imm_q <= '0;
      skid_pc_q  <= '0;
    end else begin
      if (load_out_skid_c) begin
        out_q     <= skid_q;
        out_imm_q <= skid_imm_q;
        out_pc_q  <= skid_pc_q;
      end else if (load_out_in_c) begin
        out_q     <= dec_c;
        out_imm_q <= dec_imm_c;
        out_pc_q  <= in_pc;
      end
      if (load_skid_c) begin
        skid_q     <= dec_c;
        skid_imm_q <= dec_imm_c;
        skid_pc_q  <= in_pc;
      end
    end
  end

  assign out_pc      = out_pc_q;
  assign out_fmt     = out_q.fmt;
  assign out_opcode  = out_q.opcode;
  assign out_rm      = out_q.rm;
  assign out_rn      = out_q.rn;
  assign out_rd      = out_q.rd;
  assign out_shamt   = out_q.shamt;
  assign out_imm     = out_imm_q;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: directed LEGv8 words, stall, flush and reset.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [2:0]  out_fmt;
  logic [10:0] out_opcode;
  logic [4:0]  out_rm, out_rn, out_rd;
  logic [5:0]  out_shamt;
  logic [63:0] out_imm;
  logic        out_illegal;

  typedef struct {
    logic [63:0] pc;
    logic [2:0]  fmt;
    logic [4:0]  rm;
    logic [4:0]  rn;
    logic [4:0]  rd;
    logic [63:0] imm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  logic        hold_v = 1'b0;
  logic [63:0] hold_pc, hold_imm;
  logic [2:0]  hold_fmt;

  instr_decode_stage dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_fmt     (out_fmt),
    .out_opcode  (out_opcode),
    .out_rm      (out_rm),
    .out_rn      (out_rn),
    .out_rd      (out_rd),
    .out_shamt   (out_shamt),
    .out_imm     (out_imm),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Monitor: pops on each downstream transfer and checks stall stability
  always @(negedge clk) begin
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("stall_hold_pc", out_pc, hold_pc);
        chk("stall_hold_imm", out_imm, hold_imm);
        chk("stall_hold_fmt", 64'(out_fmt), 64'(hold_fmt));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output got pc=0x%0h exp=none", out_pc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_fmt", 64'(out_fmt), 64'(e.fmt));
          chk("out_rm", 64'(out_rm), 64'(e.rm));
          chk("out_rn", 64'(out_rn), 64'(e.rn));
          chk("out_rd", 64'(out_rd), 64'(e.rd));
          chk("out_imm", out_imm, e.imm);
          chk("out_illegal", 64'(out_illegal), 64'(e.fmt == 3'd7));
        end
      end
      hold_v   = out_valid && !out_ready && !flush;
      hold_pc  = out_pc;
      hold_imm = out_imm;
      hold_fmt = out_fmt;
    end
  end

  // Offer one word, wait (bounded) for acceptance, then record its expected decode
  task automatic send(input logic [31:0] w, input logic [63:0] pc, input logic [2:0] fmt,
                      input logic [4:0] rm, input logic [4:0] rn, input logic [4:0] rd,
                      input logic [63:0] imm);
    exp_t e;
    e.pc = pc; e.fmt = fmt; e.rm = rm; e.rn = rn; e.rd = rd; e.imm = imm;
    in_valid = 1'b1;
    in_instr = w;
    in_pc    = pc;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    failures++;
    $display("FAIL send_timeout got in_ready=0 exp=1 pc=0x%0h", pc);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    // Reset held for two clocks
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_imm", out_imm, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Streaming decode of each format
    out_ready = 1'b1;
    send(32'h91001441, 64'h1000, 3'd1, 5'd0,  5'd2,  5'd1,  64'd5);
    send(32'hF85F8083, 64'h1004, 3'd2, 5'd31, 5'd4,  5'd3,  64'hFFFF_FFFF_FFFF_FFF8);
    send(32'h17FFFFFF, 64'h1008, 3'd3, 5'd31, 5'd31, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    send(32'hB4000065, 64'h100C, 3'd4, 5'd0,  5'd3,  5'd5,  64'd3);
    send(32'h00000000, 64'h1010, 3'd7, 5'd0,  5'd0,  5'd0,  64'd0);
    send(32'h8B030041, 64'h1014, 3'd0, 5'd3,  5'd2,  5'd1,  64'd0);
    send(32'hD2824680, 64'h1018, 3'd5, 5'd2,  5'd20, 5'd0,  64'h1234);
    send(32'h913FFC00, 64'h101C, 3'd1, 5'd31, 5'd0,  5'd0,  64'hFFF);
    drain();

    // Stall: A to output reg, B to skid, C blocked
    out_ready = 1'b0;
    send(32'hCB030041, 64'h2000, 3'd0, 5'd3, 5'd2, 5'd1, 64'd0);
    send(32'hF80100C5, 64'h2004, 3'd2, 5'd1, 5'd6, 5'd5, 64'd16);
    in_valid = 1'b1;
    in_instr = 32'hB5FFFFC7;
    in_pc    = 64'h2008;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_out_pc", out_pc, 64'h2000);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(32'hB5FFFFC7, 64'h2008, 3'd4, 5'd31, 5'd30, 5'd7, 64'hFFFF_FFFF_FFFF_FFFE);
    drain();

    // Flush with two entries held and a third word offered
    out_ready = 1'b0;
    send(32'h91001441, 64'h3000, 3'd1, 5'd0, 5'd2, 5'd1, 64'd5);
    send(32'h8B030041, 64'h3004, 3'd0, 5'd3, 5'd2, 5'd1, 64'd0);
    in_valid = 1'b1;
    in_instr = 32'h17FFFFFF;
    in_pc    = 64'h3008;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send(32'h94000004, 64'h4000, 3'd3, 5'd0, 5'd0, 5'd4, 64'd4);
    drain();

    // Reset mid-stream zeroes held data
    out_ready = 1'b0;
    send(32'hF85F8083, 64'h5000, 3'd2, 5'd31, 5'd4, 5'd3, 64'hFFFF_FFFF_FFFF_FFF8);
    @(negedge clk);
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_imm", out_imm, 64'd0);
    chk("mid_rst_out_pc", out_pc, 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
